// File: rtl/barrel_unshifter_pipe.sv
// barrel_unshifter_pipe: pipelined lane de-rotator, one log2 stage per select bit,
// with valid/ready flow control that stalls every stage together.
`default_nettype none

module barrel_unshifter_pipe #(
  parameter int WIDTH = 8,
  parameter int PORT  = 8,
  parameter int SHIFT = $clog2(PORT),
  parameter int WIDE  = WIDTH * PORT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SHIFT-1:0] in_select,
  input  logic [WIDE-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDE-1:0]  out_data,
  output logic             busy
);

  logic              en;
  logic [SHIFT-1:0]  stage_valid;
  logic [SHIFT-1:0]  stage_sel  [SHIFT];
  logic [WIDE-1:0]   stage_data [SHIFT];

  // out lane i takes in lane (i - r) mod PORT; r is a per-stage constant
  function automatic logic [WIDE-1:0] rotate_up(input logic [WIDE-1:0] d, input int r);
    logic [WIDE-1:0] o;
    o = '0;
    for (int i = 0; i < PORT; i++) begin
      o[i*WIDTH +: WIDTH] = d[((i + PORT - r) % PORT)*WIDTH +: WIDTH];
    end
    return o;
  endfunction

  assign en        = !out_valid || out_ready;
  assign in_ready  = en;
  assign out_valid = stage_valid[SHIFT-1];
  assign out_data  = stage_data[SHIFT-1];
  assign busy      = |stage_valid;

  for (genvar k = 0; k < SHIFT; k++) begin : g_stage
    // Unreduced selects >= PORT still land on select mod PORT because each
    // bit contributes 2^k mod PORT lanes.
    localparam int ROT = (1 << k) % PORT;

    logic             v_in;
    logic [SHIFT-1:0] s_in;
    logic [WIDE-1:0]  d_in;
    logic             valid_r;
    logic [SHIFT-1:0] sel_r;
    logic [WIDE-1:0]  data_r;

    if (k == 0) begin : g_first
      assign v_in = in_valid;
      assign s_in = in_select;
      assign d_in = in_data;
    end else begin : g_next
      assign v_in = stage_valid[k-1];
      assign s_in = stage_sel[k-1];
      assign d_in = stage_data[k-1];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_r <= 1'b0;
        sel_r   <= '0;
        data_r  <= '0;
      end else if (en) begin
        valid_r <= v_in;
        sel_r   <= s_in & ~(SHIFT'(1) << k);
        data_r  <= s_in[k] ? rotate_up(d_in, ROT) : d_in;
      end
    end

    assign stage_valid[k] = valid_r;
    assign stage_sel[k]   = sel_r;
    assign stage_data[k]  = data_r;
  end

endmodule

`default_nettype wire
